// File: rtl/reg_file_wr_ctrl.sv
// Write-side initiator: serialises a masked WIDTH-bit word into one-bit write strobes.
// Optional readback compare of the written word is enabled by defining READBACK_CHECK_EN.
module reg_file_wr_ctrl #(
  parameter int WIDTH  = 2,
  parameter int ADDR_W = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [WIDTH-1:0]  in_mask,
  output logic              r_d_wen_out,
  output logic [ADDR_W-1:0] r_d_waddr_out,
  output logic              d_out,
  output logic              busy,
`ifdef READBACK_CHECK_EN
  input  logic [WIDTH-1:0]  a_in,
  output logic              err,
`endif
  output logic              done
);

`ifdef READBACK_CHECK_EN
  typedef enum logic [1:0] {IDLE, WRITE, CHECK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WIDTH - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [WIDTH-1:0]  data_reg, data_next;
  logic [WIDTH-1:0]  mask_reg, mask_next;
`ifdef READBACK_CHECK_EN
  logic              err_reg, err_next;
  logic [WIDTH-1:0]  mismatch;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cmp
    assign mismatch[gi] = (a_in[gi] ^ data_reg[gi]) & mask_reg[gi];
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      data_reg  <= '0;
      mask_reg  <= '0;
`ifdef READBACK_CHECK_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      mask_reg  <= mask_next;
`ifdef READBACK_CHECK_EN
      err_reg   <= err_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    mask_next  = mask_reg;
`ifdef READBACK_CHECK_EN
    err_next   = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          data_next  = in_data;
          mask_next  = in_mask;
          idx_next   = '0;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (idx_reg == LAST_IDX) begin
`ifdef READBACK_CHECK_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end else begin
          idx_next = idx_reg + ADDR_W'(1);
        end
      end
`ifdef READBACK_CHECK_EN
      CHECK: begin
        err_next   = |mismatch;
        state_next = DONE;
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode registered state only, so nothing from the inputs reaches them.
  always_comb begin
    in_ready      = (state_reg == IDLE);
    busy          = (state_reg != IDLE);
    done          = (state_reg == DONE);
    r_d_wen_out   = 1'b0;
    r_d_waddr_out = '0;
    d_out         = 1'b0;
`ifdef READBACK_CHECK_EN
    err           = (state_reg == DONE) & err_reg;
`endif
    if (state_reg == WRITE) begin
      r_d_waddr_out = idx_reg;
      d_out         = data_reg[idx_reg];
      r_d_wen_out   = mask_reg[idx_reg];
    end
  end

endmodule
